// File: rtl/neuron_core_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : neuron_core_controller_if
// Purpose  : Scheduler, SRAM, router and tick/busy signals of the neuron core.
// Revision : 1.0 - initial release
// ============================================================================
interface neuron_core_controller_if #(
  parameter int NID_W   = 8,
  parameter int PKT_W   = 28,
  parameter int V_WIDTH = 16
);
  logic               tick;
  logic [PKT_W-1:0]   sched_pkt;
  logic               sched_pkt_valid;
  logic               dropped_c2r;
  logic               busy;
  logic [NID_W-1:0]   mem_addr;
  logic               mem_rd_en;
  logic               mem_wr_en;
  logic [V_WIDTH-1:0] mem_wdata;
  logic [V_WIDTH-1:0] mem_rdata;
  logic               spike_valid;
  logic [NID_W-1:0]   spike_nid;

  // The controller side drives the SRAM and router signals.
  modport master (
    input  tick, sched_pkt, sched_pkt_valid, mem_rdata,
    output dropped_c2r, busy, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
           spike_valid, spike_nid
  );

  modport slave (
    output tick, sched_pkt, sched_pkt_valid, mem_rdata,
    input  dropped_c2r, busy, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
           spike_valid, spike_nid
  );
endinterface
`default_nettype wire

// File: rtl/neuron_core_controller.sv
`default_nettype none
// ============================================================================
// Module   : neuron_core_controller
// Purpose  : Event-driven read/integrate/threshold/write-back neuron sequencer.
//            Optional per-tick leak sweep enabled by NEURON_CORE_LEAK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_core_controller #(
  parameter int N_COUNT     = 256,
  parameter int GRANULARITY = 4,
  parameter int PKT_SIZE    = 32,
  parameter int V_WIDTH     = 16,
  parameter int W_WIDTH     = 12,
  parameter int THRESHOLD   = 100,
  parameter int RESET_V     = 0,
  parameter int LEAK        = 1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  neuron_core_controller_if.master bus
);
  localparam int NID_W = $clog2(N_COUNT);
  localparam int PKT_W = PKT_SIZE - GRANULARITY;

  localparam logic signed [V_WIDTH-1:0] c_threshold = V_WIDTH'(THRESHOLD);
  localparam logic signed [V_WIDTH-1:0] c_reset_v   = V_WIDTH'(RESET_V);
  localparam logic signed [V_WIDTH-1:0] c_v_max     = {1'b0, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [V_WIDTH-1:0] c_v_min     = {1'b1, {(V_WIDTH-1){1'b0}}};

  if (W_WIDTH > V_WIDTH || LEAK < 0 || LEAK >= 2**(V_WIDTH-1)
      || PKT_W < NID_W + W_WIDTH + 8) begin : g_param_check
    $error("neuron_core_controller: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_UPDATE  = 3'd2
`ifdef NEURON_CORE_LEAK_EN
    ,
    S_LK_RD   = 3'd3,
    S_LK_WAIT = 3'd4,
    S_LK_WR   = 3'd5
`endif
  } state_t;

  state_t                      r_state;
  logic [NID_W-1:0]            r_nid;
  logic signed [W_WIDTH-1:0]   r_weight;
  logic [NID_W-1:0]            r_mem_addr;
  logic                        r_mem_rd_en;
  logic                        r_mem_wr_en;
  logic signed [V_WIDTH-1:0]   r_mem_wdata;
  logic                        r_spike_valid;
  logic [NID_W-1:0]            r_spike_nid;
  logic                        r_dropped;
  logic                        r_busy;

  logic [NID_W-1:0]            w_pkt_nid;
  logic signed [W_WIDTH-1:0]   w_pkt_weight;
  logic signed [V_WIDTH:0]     w_sum;
  logic signed [V_WIDTH-1:0]   w_sat;
  logic                        w_fire;

  assign w_pkt_nid    = bus.sched_pkt[PKT_W-1 -: NID_W];
  assign w_pkt_weight = bus.sched_pkt[8 +: W_WIDTH];

  // One guard bit so the add cannot wrap before saturation.
  assign w_sum = {bus.mem_rdata[V_WIDTH-1], bus.mem_rdata}
               + {{(V_WIDTH+1-W_WIDTH){r_weight[W_WIDTH-1]}}, r_weight};

  always_comb begin
    w_sat = w_sum[V_WIDTH-1:0];
    if (w_sum[V_WIDTH] != w_sum[V_WIDTH-1]) begin
      w_sat = w_sum[V_WIDTH] ? c_v_min : c_v_max;
    end
  end

  assign w_fire = (w_sat >= c_threshold);

`ifdef NEURON_CORE_LEAK_EN
  localparam logic signed [V_WIDTH-1:0] c_leak     = V_WIDTH'(LEAK);
  localparam logic [NID_W-1:0]          c_last_nid = NID_W'(N_COUNT - 1);

  logic                      r_tick_d;
  logic                      r_leak_pending;
  logic [NID_W-1:0]          r_cnt;
  logic                      w_tick_rise;
  logic signed [V_WIDTH-1:0] w_rd_v;
  logic signed [V_WIDTH-1:0] w_leak_v;

  assign w_tick_rise = bus.tick & ~r_tick_d;
  assign w_rd_v      = bus.mem_rdata;

  // Move toward zero by LEAK; anything within LEAK of zero collapses to zero.
  always_comb begin
    w_leak_v = '0;
    if (w_rd_v > c_leak) begin
      w_leak_v = w_rd_v - c_leak;
    end else if (w_rd_v < -c_leak) begin
      w_leak_v = w_rd_v + c_leak;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_nid         <= '0;
      r_weight      <= '0;
      r_mem_addr    <= '0;
      r_mem_rd_en   <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wdata   <= '0;
      r_spike_valid <= 1'b0;
      r_spike_nid   <= '0;
      r_dropped     <= 1'b0;
      r_busy        <= 1'b0;
`ifdef NEURON_CORE_LEAK_EN
      r_tick_d       <= 1'b0;
      r_leak_pending <= 1'b0;
      r_cnt          <= '0;
`endif
    end else begin
      r_mem_rd_en   <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_spike_valid <= 1'b0;
      r_dropped     <= 1'b0;

      case (r_state)
        S_IDLE: begin
`ifdef NEURON_CORE_LEAK_EN
          if (r_leak_pending) begin
            r_leak_pending <= 1'b0;
            r_cnt          <= '0;
            r_state        <= S_LK_RD;
            r_busy         <= 1'b1;
            r_dropped      <= bus.sched_pkt_valid;
          end else
`endif
          if (bus.sched_pkt_valid) begin
            r_nid       <= w_pkt_nid;
            r_weight    <= w_pkt_weight;
            r_mem_addr  <= w_pkt_nid;
            r_mem_rd_en <= 1'b1;
            r_state     <= S_RD_WAIT;
            r_busy      <= 1'b1;
          end
        end
        S_RD_WAIT: begin
          r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          if (w_fire) begin
            r_mem_wdata   <= c_reset_v;
            r_spike_valid <= 1'b1;
            r_spike_nid   <= r_nid;
          end else begin
            r_mem_wdata <= w_sat;
          end
          r_mem_wr_en <= 1'b1;
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
        end
`ifdef NEURON_CORE_LEAK_EN
        S_LK_RD: begin
          r_mem_addr  <= r_cnt;
          r_mem_rd_en <= 1'b1;
          r_state     <= S_LK_WAIT;
        end
        S_LK_WAIT: begin
          r_state <= S_LK_WR;
        end
        S_LK_WR: begin
          r_mem_wdata <= w_leak_v;
          r_mem_wr_en <= 1'b1;
          r_cnt       <= r_cnt + 1'b1;
          if (r_cnt == c_last_nid) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_LK_RD;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (bus.sched_pkt_valid && (r_state != S_IDLE)) begin
        r_dropped <= 1'b1;
      end

`ifdef NEURON_CORE_LEAK_EN
      // A tick edge arriving while a sweep starts queues one more sweep.
      r_tick_d <= bus.tick;
      if (w_tick_rise) begin
        r_leak_pending <= 1'b1;
      end
`endif
    end
  end

  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_rd_en   = r_mem_rd_en;
  assign bus.mem_wr_en   = r_mem_wr_en;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.spike_valid = r_spike_valid;
  assign bus.spike_nid   = r_spike_nid;
  assign bus.dropped_c2r = r_dropped;
  assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_neuron_core_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_core_controller
// Purpose  : Directed self-checking bench; two cores share clk/rst, one with
//            THRESHOLD raised to 32767. Leak checks need NEURON_CORE_LEAK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_core_controller;
  localparam int N     = 256;
  localparam int NID_W = 8;
  localparam int PKT_W = 28;
  localparam int V_W   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_core_controller_if #(.NID_W(NID_W), .PKT_W(PKT_W), .V_WIDTH(V_W)) ifa ();
  neuron_core_controller_if #(.NID_W(NID_W), .PKT_W(PKT_W), .V_WIDTH(V_W)) ifb ();

  neuron_core_controller #(.N_COUNT(N)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  neuron_core_controller #(.N_COUNT(N), .THRESHOLD(32767)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  logic signed [V_W-1:0] mem_a [N];
  logic signed [V_W-1:0] mem_b [N];
  logic                  pre_wea, pre_web;
  logic [NID_W-1:0]      pre_addr;
  logic signed [V_W-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_wea) mem_a[pre_addr] <= pre_data;
    else if (ifa.mem_wr_en) mem_a[ifa.mem_addr] <= ifa.mem_wdata;
    if (pre_web) mem_b[pre_addr] <= pre_data;
    else if (ifb.mem_wr_en) mem_b[ifb.mem_addr] <= ifb.mem_wdata;
    if (ifa.mem_rd_en) ifa.mem_rdata <= mem_a[ifa.mem_addr];
    if (ifb.mem_rd_en) ifb.mem_rdata <= mem_b[ifb.mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PKT_W-1:0] pkt(input logic [7:0] nid,
                                           input logic signed [11:0] w);
    logic [PKT_W-1:0] p;
    p = '0;
    p[PKT_W-1 -: NID_W] = nid;
    p[8 +: 12]          = w;
    p[7:0]              = 8'h5A;
    return p;
  endfunction

  task automatic poke_a(input logic [7:0] a, input logic signed [V_W-1:0] d);
    pre_wea = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_wea = 1'b0;
  endtask

  task automatic poke_b(input logic [7:0] a, input logic signed [V_W-1:0] d);
    pre_web = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_web = 1'b0;
  endtask

  // Leaves the bench one step after the accepting edge (E0 + 1).
  task automatic send_a(input logic [7:0] nid, input logic signed [11:0] w);
    ifa.sched_pkt = pkt(nid, w);
    ifa.sched_pkt_valid = 1'b1;
    step();
    ifa.sched_pkt_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pre_wea = 1'b0; pre_web = 1'b0; pre_addr = '0; pre_data = '0;
    ifa.tick = 1'b0; ifa.sched_pkt = '0; ifa.sched_pkt_valid = 1'b0;
    ifb.tick = 1'b0; ifb.sched_pkt = '0; ifb.sched_pkt_valid = 1'b0;
    ifa.mem_rdata = '0; ifb.mem_rdata = '0;

    pre_wea = 1'b1; pre_web = 1'b1;
    for (int i = 0; i < N; i++) begin
      pre_addr = 8'(i);
      step();
    end
    pre_wea = 1'b0; pre_web = 1'b0;
    rst = 1'b0;
    step();

    check_eq("rst_busy",      ifa.busy, 0);
    check_eq("rst_rd_en",     ifa.mem_rd_en, 0);
    check_eq("rst_wr_en",     ifa.mem_wr_en, 0);
    check_eq("rst_spike",     ifa.spike_valid, 0);
    check_eq("rst_drop",      ifa.dropped_c2r, 0);
    check_eq("rst_addr",      ifa.mem_addr, 0);
    check_eq("rst_wdata",     ifa.mem_wdata, 0);
    check_eq("rst_spike_nid", ifa.spike_nid, 0);

    // Integrate without firing: 40 + 30 = 70.
    poke_a(8'd5, 16'sd40);
    send_a(8'd5, 12'sd30);
    check_eq("int_rd_en",  ifa.mem_rd_en, 1);
    check_eq("int_addr",   ifa.mem_addr, 5);
    check_eq("int_busy",   ifa.busy, 1);
    step();
    check_eq("int_rd_off", ifa.mem_rd_en, 0);
    step();
    check_eq("int_wr_en",  ifa.mem_wr_en, 1);
    check_eq("int_wdata",  $signed(ifa.mem_wdata), 70);
    check_eq("int_spike",  ifa.spike_valid, 0);
    step();
    check_eq("int_wr_off", ifa.mem_wr_en, 0);
    check_eq("int_idle",   ifa.busy, 0);
    check_eq("int_mem",    mem_a[5], 70);

    // Fire exactly at threshold: 90 + 10 = 100.
    poke_a(8'd7, 16'sd90);
    send_a(8'd7, 12'sd10);
    step(); step();
    check_eq("fire_wr_en", ifa.mem_wr_en, 1);
    check_eq("fire_wdata", $signed(ifa.mem_wdata), 0);
    check_eq("fire_spike", ifa.spike_valid, 1);
    check_eq("fire_nid",   ifa.spike_nid, 7);
    step();
    check_eq("fire_spike_off", ifa.spike_valid, 0);

    // Negative saturation, no spike.
    poke_a(8'd4, -16'sd32768);
    send_a(8'd4, -12'sd2048);
    step(); step();
    check_eq("negsat_wdata", $signed(ifa.mem_wdata), -32768);
    check_eq("negsat_spike", ifa.spike_valid, 0);
    step();

    // Positive saturation reaches THRESHOLD=32767 only if clamped, and fires.
    poke_b(8'd3, 16'sd32760);
    ifb.sched_pkt = pkt(8'd3, 12'sd2047);
    ifb.sched_pkt_valid = 1'b1;
    step();
    ifb.sched_pkt_valid = 1'b0;
    step(); step();
    check_eq("possat_wr_en", ifb.mem_wr_en, 1);
    check_eq("possat_spike", ifb.spike_valid, 1);
    check_eq("possat_nid",   ifb.spike_nid, 3);
    check_eq("possat_wdata", $signed(ifb.mem_wdata), 0);
    step();

    // Packets at E0, E1, E3 on the same neuron: middle one dropped.
    poke_a(8'd9, 16'sd10);
    ifa.sched_pkt = pkt(8'd9, 12'sd5);
    ifa.sched_pkt_valid = 1'b1;
    step();
    check_eq("b2b_rd0", ifa.mem_rd_en, 1);
    ifa.sched_pkt = pkt(8'd9, 12'sd100);
    step();
    check_eq("b2b_drop",   ifa.dropped_c2r, 1);
    check_eq("b2b_rd_off", ifa.mem_rd_en, 0);
    ifa.sched_pkt_valid = 1'b0;
    step();
    check_eq("b2b_drop_off", ifa.dropped_c2r, 0);
    check_eq("b2b_wr0",      ifa.mem_wr_en, 1);
    check_eq("b2b_wdata0",   $signed(ifa.mem_wdata), 15);
    ifa.sched_pkt = pkt(8'd9, 12'sd7);
    ifa.sched_pkt_valid = 1'b1;
    step();
    check_eq("b2b_rd3",     ifa.mem_rd_en, 1);
    check_eq("b2b_wr0_off", ifa.mem_wr_en, 0);
    ifa.sched_pkt_valid = 1'b0;
    step(); step();
    check_eq("b2b_wr3",    ifa.mem_wr_en, 1);
    check_eq("b2b_wdata3", $signed(ifa.mem_wdata), 22);
    step();

    // Reset during RD_WAIT aborts the operation.
    send_a(8'd7, 12'sd50);
    rst = 1'b1;
    step();
    check_eq("abort_wr_en", ifa.mem_wr_en, 0);
    check_eq("abort_spike", ifa.spike_valid, 0);
    check_eq("abort_busy",  ifa.busy, 0);
    check_eq("abort_rd_en", ifa.mem_rd_en, 0);
    check_eq("abort_addr",  ifa.mem_addr, 0);
    rst = 1'b0;
    step();
    check_eq("abort_wr_after",    ifa.mem_wr_en, 0);
    check_eq("abort_spike_after", ifa.spike_valid, 0);
    check_eq("abort_mem",         mem_a[7], 0);

`ifdef NEURON_CORE_LEAK_EN
    begin
      int spikes = 0;
      int guard  = 0;
      poke_a(8'd0, 16'sd5);
      poke_a(8'd1, -16'sd1);
      poke_a(8'd2, 16'sd0);
      ifa.tick = 1'b1;
      step();
      check_eq("leak_pending_idle", ifa.busy, 0);
      step();
      check_eq("leak_busy", ifa.busy, 1);
      ifa.tick = 1'b0;
      send_a(8'd5, 12'sd1);
      check_eq("leak_drop", ifa.dropped_c2r, 1);
      while (ifa.busy && guard < 3 * N + 20) begin
        step();
        guard++;
        if (ifa.spike_valid) spikes++;
      end
      check_eq("leak_done", ifa.busy, 0);
      step();
      check_eq("leak_spikes", spikes, 0);
      check_eq("leak_n0", mem_a[0], 4);
      check_eq("leak_n1", mem_a[1], 0);
      check_eq("leak_n2", mem_a[2], 0);
      check_eq("leak_n5", mem_a[5], 69);
      check_eq("leak_n9", mem_a[9], 21);
    end
`else
    ifa.tick = 1'b1;
    step(); step();
    check_eq("tick_ignored_busy", ifa.busy, 0);
    check_eq("tick_ignored_rd",   ifa.mem_rd_en, 0);
    ifa.tick = 1'b0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
